// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: per-stage stall merge, deferred exception flush sequencing
// and stall watchdog for an in-order pipeline.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the perf_stall_cyc and
// perf_flush_cnt performance counters.
module pipe_ctrl_unit #(
  parameter int unsigned           STAGES    = 6,
  parameter int unsigned           NREQ      = 5,
  parameter int unsigned           SW        = 3,
  parameter logic [NREQ*SW-1:0]    REQ_STAGE = {3'd5, 3'd3, 3'd2, 3'd2, 3'd2},
  parameter int unsigned           WDT_LIMIT = 1024,
  parameter int unsigned           CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq,
  input  logic              cache_stall,
  input  logic              excp_valid,
  input  logic [31:0]       excp_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_FLUSH_PEND = 2'd1;
  localparam logic [1:0] S_FLUSH      = 2'd2;

  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

  logic [1:0]        r_state;
  logic [31:0]       r_pend_pc;
  logic [SW-1:0]     w_req_stage [NREQ];
  logic [SW-1:0]     w_max_stage;
  logic              w_any_req;
  logic [STAGES-1:0] w_stall_vec;

  // Out-of-range stage indices collapse onto the last stage (WB).
  for (genvar g = 0; g < NREQ; g++) begin : g_clamp
    assign w_req_stage[g] = (32'(REQ_STAGE[g*SW +: SW]) > STAGES - 1)
                          ? LAST_STAGE : REQ_STAGE[g*SW +: SW];
  end

  // Deepest requested stage among active sources; everything upstream holds too.
  always_comb begin
    w_max_stage = '0;
    w_any_req   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (stallreq[i]) begin
        w_any_req = 1'b1;
        if (w_req_stage[i] > w_max_stage) w_max_stage = w_req_stage[i];
      end
    end
    for (int unsigned j = 0; j < STAGES; j++) begin
      w_stall_vec[j] = w_any_req && (j <= 32'(w_max_stage));
    end
  end

  // Stalls are released during the flush cycle so flushed stages load bubbles.
  assign stall  = (rst || r_state == S_FLUSH) ? '0 : w_stall_vec;
  assign flush  = (r_state == S_FLUSH);
  assign new_pc = flush ? r_pend_pc : '0;

  // Exception sequencing: latch the oldest exception, defer it past a cache stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_pend_pc <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (excp_valid) begin
            r_pend_pc <= excp_pc;
            r_state   <= cache_stall ? S_FLUSH_PEND : S_FLUSH;
          end
        end
        S_FLUSH_PEND: begin
          if (!cache_stall) r_state <= S_FLUSH;
        end
        S_FLUSH: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  if (WDT_LIMIT != 0) begin : g_wdt
    localparam int unsigned     WDT_W   = $clog2(WDT_LIMIT + 1);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);
    localparam logic [WDT_W-1:0] WDT_PRE = WDT_W'(WDT_LIMIT - 1);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_timeout;

    // Count consecutive stalled cycles; the timeout flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wdt_cnt <= '0;
        r_timeout <= 1'b0;
      end else if (|stall) begin
        if (r_wdt_cnt != WDT_MAX) r_wdt_cnt <= r_wdt_cnt + 1'b1;
        if (r_wdt_cnt == WDT_PRE) r_timeout <= 1'b1;
      end else begin
        r_wdt_cnt <= '0;
      end
    end

    assign stall_timeout = r_timeout;
  end else begin : g_no_wdt
    assign stall_timeout = 1'b0;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_perf_stall_cyc;
  logic [CNT_W-1:0] r_perf_flush_cnt;

  // Free-running perf counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall_cyc <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (stall[0]) r_perf_stall_cyc <= r_perf_stall_cyc + 1'b1;
      if (flush)    r_perf_flush_cnt <= r_perf_flush_cnt + 1'b1;
    end
  end

  assign perf_stall_cyc = r_perf_stall_cyc;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: stall merge, flush sequencing, watchdog, reset.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stallreq;
  logic        cache_stall;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic [5:0]  stall,  stall0;
  logic        flush,  flush0;
  logic [31:0] new_pc, new_pc0;
  logic        stall_timeout, stall_timeout0;
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0]  perf_stall_cyc, perf_flush_cnt, perf_stall_cyc0, perf_flush_cnt0;
  logic [3:0]  m_ps, m_pf;
`endif

  // Source 3 uses an out-of-range index that must behave as stage 5.
  pipe_ctrl_unit #(.STAGES(6), .NREQ(5), .SW(3),
    .REQ_STAGE({3'd5, 3'd7, 3'd1, 3'd0, 3'd2}), .WDT_LIMIT(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .cache_stall(cache_stall),
    .excp_valid(excp_valid), .excp_pc(excp_pc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_timeout(stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  pipe_ctrl_unit #(.STAGES(6), .NREQ(5), .SW(3),
    .REQ_STAGE({3'd5, 3'd7, 3'd1, 3'd0, 3'd2}), .WDT_LIMIT(0), .CNT_W(4)) u_dut_nowdt (
    .clk(clk), .rst(rst), .stallreq(stallreq), .cache_stall(cache_stall),
    .excp_valid(excp_valid), .excp_pc(excp_pc), .stall(stall0), .flush(flush0),
    .new_pc(new_pc0), .stall_timeout(stall_timeout0)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc0), .perf_flush_cnt(perf_flush_cnt0)
`endif
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          tbl [5]  = '{2, 0, 1, 5, 5};
  logic [31:0] sb_pc [$];
  int          m_st;
  int          m_cnt;
  logic        m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_merge(input logic [4:0] r);
    int k = -1;
    for (int i = 0; i < 5; i++)
      if (r[i] && tbl[i] > k) k = tbl[i];
    if (k < 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_to = 1'b0;
    sb_pc.delete();
`ifdef PIPE_CTRL_PERF_EN
    m_ps = '0; m_pf = '0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"},  stall,  0);
    check_eq({tag, "_flush"},  flush,  0);
    check_eq({tag, "_new_pc"}, new_pc, 0);
    check_eq({tag, "_tmo"},    stall_timeout, 0);
`ifdef PIPE_CTRL_PERF_EN
    check_eq({tag, "_pstall"}, perf_stall_cyc, 0);
    check_eq({tag, "_pflush"}, perf_flush_cnt, 0);
`endif
  endtask

  // One clock cycle: entered just after a rising edge, leaves just after the next.
  task automatic cyc(input logic [4:0] req, input logic cs, input logic ev, input logic [31:0] pc);
    logic       e_flush;
    logic [5:0] e_stall;
    stallreq = req; cache_stall = cs; excp_valid = ev; excp_pc = pc;
    e_flush = (m_st == 2);
    e_stall = e_flush ? 6'd0 : exp_merge(req);
    @(negedge clk);
    check_eq("stall", stall, e_stall);
    check_eq("flush", flush, e_flush);
    if (flush) begin
      if (sb_pc.size() == 0) check_eq("sb_spurious", flush, 0);
      else                   check_eq("new_pc", new_pc, sb_pc.pop_front());
    end else begin
      check_eq("new_pc_idle", new_pc, 0);
    end
    check_eq("timeout", stall_timeout, m_to);
    check_eq("timeout_nowdt", stall_timeout0, 0);
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf_stall", perf_stall_cyc, m_ps);
    check_eq("perf_flush", perf_flush_cnt, m_pf);
`endif
    @(posedge clk);
    case (m_st)
      0: if (ev) begin sb_pc.push_back(pc); m_st = cs ? 1 : 2; end
      1: if (!cs) m_st = 2;
      default: m_st = 0;
    endcase
    if (e_stall != 0) begin
      if (m_cnt < 8) m_cnt++;
      if (m_cnt == 8) m_to = 1'b1;
    end else begin
      m_cnt = 0;
    end
`ifdef PIPE_CTRL_PERF_EN
    if (e_stall[0]) m_ps = m_ps + 4'd1;
    if (e_flush)    m_pf = m_pf + 4'd1;
`endif
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stallreq = 5'b10000; cache_stall = 1'b0; excp_valid = 1'b0; excp_pc = '0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Stall merge: single source, max-wins, clamp, stage-0-only, idle
    cyc(5'b00001, 0, 0, 0);
    cyc(5'b10001, 0, 0, 0);
    cyc(5'b00100, 0, 0, 0);
    cyc(5'b00010, 0, 0, 0);
    cyc(5'b01000, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);

    // Immediate flush; stall forced low during flush cycle
    cyc(5'b00000, 0, 1, 32'hBFC0_0380);
    cyc(5'b00001, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);

    // Exception arriving during the flush cycle is ignored
    cyc(5'b00000, 0, 1, 32'h0000_1111);
    cyc(5'b00000, 0, 1, 32'h0000_2222);
    cyc(5'b00000, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);

    // Deferred flush: oldest exception wins, issued after cache_stall drops
    for (int i = 0; i < 10; i++)
      cyc(5'b00000, 1, (i == 2) || (i == 5),
          (i == 2) ? 32'hA000_00A0 : ((i == 5) ? 32'hB000_00B0 : 32'h0));
    cyc(5'b00000, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);

    // Watchdog: 7 stalls then a gap must not trip; 8 consecutive must, sticky
    for (int i = 0; i < 7; i++) cyc(5'b00100, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(5'b10000, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(5'b00000, 0, 0, 0);
    check_eq("timeout_sticky", stall_timeout, 1);

    // Asynchronous reset in FLUSH_PEND discards the pending flush
    cyc(5'b10000, 1, 1, 32'hDEAD_0004);
    cyc(5'b10000, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(5'b00000, 0, 0, 0);
    cyc(5'b00001, 0, 0, 0);

    check_eq("sb_drain", sb_pc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
